data_memory_access_controller: RTL
==================================

// Module: data_memory_access_controller
// PURPOSE
//  Initiator side of the data memory port. Accepts one load/store request at a
//  time from the non-pipelined MIPS datapath and forms the effective address
//  (base + sign-extended offset). Range-checks that address, then drives the
//  data memory's address/write_data/write_enable/read_enable and samples its
//  read_data. Returns the result over a valid/ready response channel.
// PARAMETERS
//  MEM_DEPTH    512  number of addressable words; address >= MEM_DEPTH is an error
//  READ_WAIT    0    extra cycles read_enable is held before read data is sampled (0..15)
// PORTS
//  clk             in   1   single clock, all state updates on posedge
//  reset           in   1   asynchronous, active-high; clears all state
//  req_valid       in   1   request present
//  req_ready       out  1   controller can accept a request (=1 only in IDLE)
//  req_write       in   1   1 = store, 0 = load
//  req_base        in   16  base register value
//  req_offset      in   16  signed immediate offset
//  req_wdata       in   16  store data
//  resp_valid      out  1   response present
//  resp_ready      in   1   datapath takes response
//  resp_rdata      out  16  load data (0 for stores and errors)
//  resp_error      out  1   effective address out of range; no memory access made
//  mem_address     out  16  to data memory address
//  mem_write_data  out  16  to data memory write_data
//  mem_write_enable out 1   to data memory write_enable
//  mem_read_enable out  1   to data memory read_enable
//  mem_read_data   in   16  from data memory read_data (combinational on address)
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, all mem_* outputs 0, resp_valid=0,
//    resp_rdata=0, resp_error=0, req_ready=1. All outputs except req_ready registered.
//  - States: IDLE, ACCESS, RESP.
//  - IDLE: handshake on req_valid&&req_ready at a posedge. Capture ea =
//    req_base + req_offset, mod 2^16 (wraps, no overflow flag); capture write, wdata.
//    ea < MEM_DEPTH -> ACCESS. Otherwise -> RESP with resp_error=1, resp_rdata=0,
//    and no enable ever asserted.
//  - ACCESS store: mem_address=ea, mem_write_data=wdata, mem_write_enable=1 for
//    exactly one cycle; memory writes on the closing edge; -> RESP, rdata=0.
//  - ACCESS load: mem_address=ea, mem_read_enable=1 for READ_WAIT+1 cycles;
//    mem_read_data sampled into resp_rdata on the last such cycle; -> RESP.
//  - mem_write_enable and mem_read_enable are never high together, and never
//    high outside ACCESS. mem_address/mem_write_data return to 0 on leaving ACCESS.
//  - RESP: resp_valid=1; resp_rdata/resp_error held stable until resp_ready=1.
//    Then -> IDLE with resp_valid=0 next cycle. No new request is accepted in the
//    same cycle as the response handshake.
//  - Latency, accept edge to resp_valid high: store 2 cycles; load READ_WAIT+2
//    cycles; error 1 cycle.
//  - req_ready=0 in ACCESS and RESP; req_* inputs ignored there.
//  - Reset mid-operation: all enables drop immediately (async); the in-flight
//    request is discarded; no response is produced; a partial store is not retried.
// TESTING
//  1 Store base=0x0010 off=0x0004 wdata=0xBEEF -> one cycle we=1 addr=0x0014;
//    resp_valid 2 cycles after accept; rdata=0; err=0.
//  2 Load of test 1's address, READ_WAIT=0 and 3 -> re=1 for 1 and 4 cycles;
//    resp_rdata=0xBEEF at +2 and +5 cycles.
//  3 base=0x0005 off=0xFFFE (-2) -> ea=0x0003. base=0xFFFF off=0x0002 -> ea=0x0001 (wrap).
//  4 Load ea=0x0200 with MEM_DEPTH=512 -> resp_error=1, rdata=0,
//    re/we never asserted, resp_valid 1 cycle after accept.
//  5 Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable; req_ready=0;
//    a new req_valid is not accepted until a cycle after the response handshake.
//  6 Assert reset during load ACCESS with READ_WAIT=3 -> re=0 at once, resp_valid
//    never rises; a following store completes normally.

Source files
------------

// File: rtl/data_memory_access_controller_if.sv
// data_memory_access_controller_if: request/response channels plus data memory port.
interface data_memory_access_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_base;
  logic [15:0] req_offset;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_error;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [15:0] mem_read_data;
  modport slave (
    input  req_valid, req_write, req_base, req_offset, req_wdata, resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_write_enable, mem_read_enable
  );
  modport master (
    output req_valid, req_write, req_base, req_offset, req_wdata, resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_write_enable, mem_read_enable
  );
endinterface

// File: rtl/data_memory_access_controller.sv
// data_memory_access_controller: one-at-a-time load/store initiator for the data memory port.
module data_memory_access_controller #(
  parameter int MEM_DEPTH = 512,
  parameter int READ_WAIT = 0
) (
  input logic clk,
  input logic reset,
  data_memory_access_controller_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);
  localparam logic [3:0] RW = 4'(READ_WAIT);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [15:0] ea;
  logic done;
  assign ea = bus.req_base + bus.req_offset;
  assign bus.req_ready = state == IDLE;
  // a store always finishes after one cycle; a load after READ_WAIT+1
  assign done = bus.mem_write_enable || cnt == RW;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_write_data <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_read_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          if ({1'b0, ea} < DEPTH) begin
            state <= ACCESS;
            cnt <= '0;
            bus.mem_address <= ea;
            bus.mem_write_data <= bus.req_write ? bus.req_wdata : '0;
            bus.mem_write_enable <= bus.req_write;
            bus.mem_read_enable <= !bus.req_write;
          end else begin
            state <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b1;
            bus.resp_rdata <= '0;
          end
        end
        ACCESS: if (done) begin
          state <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= bus.mem_read_enable ? bus.mem_read_data : '0;
          bus.mem_address <= '0;
          bus.mem_write_data <= '0;
          bus.mem_write_enable <= 1'b0;
          bus.mem_read_enable <= 1'b0;
        end else cnt <= cnt + 4'd1;
        RESP: if (bus.resp_ready) begin
          state <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_error <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
